// File: rtl/wb_line_responder_if.sv
// Wishbone bus bundle for the single-line responder: one 128-bit line per beat.
// Master drives cyc/stb/we/adr/sel/dat_m and holds them stable until ack.
// Slave returns dat_s/ack; sel is an active-low byte-lane select.
interface wishbone;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  adr;
    logic [15:0]  sel;
    logic [127:0] dat_m;
    logic [127:0] dat_s;
    logic         ack;

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output dat_s, ack
    );

    modport master (
        output cyc, stb, we, adr, sel, dat_m,
        input  dat_s, ack
    );
endinterface

// File: rtl/wb_line_responder.sv
// Purpose: one-line write-back buffer between a Wishbone slave port and a line-wide physical memory.
// Latency: hit acks one cycle after acceptance; miss acks one cycle after the fill pmem_resp.
// Backpressure: requests accepted only in IDLE; pmem_read/pmem_write held until pmem_resp.
// Ports: clk, rst (sync, active-high); wb (wishbone.slave); pmem_read/pmem_write/pmem_address/
//        pmem_wdata out to memory; pmem_rdata/pmem_resp back from memory.
module wb_line_responder (
    input  logic          clk,
    input  logic          rst,
    wishbone.slave        wb,
    output logic          pmem_read,
    output logic          pmem_write,
    output logic [15:0]   pmem_address,
    output logic [127:0]  pmem_wdata,
    input  logic [127:0]  pmem_rdata,
    input  logic          pmem_resp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WBACK = 2'd1,
        FILL  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Line buffer
    logic         valid;
    logic         dirty;
    logic [11:0]  tag;
    logic [127:0] data;

    // Line address captured at acceptance so the fill address stays stable
    // even if the master abandons the cycle while memory is still busy.
    logic [11:0]  req_tag;

    logic req;
    logic hit;
    logic unused_adr_bits;

    assign req             = wb.cyc & wb.stb;
    assign hit             = valid && (tag == wb.adr[15:4]);
    assign unused_adr_bits = ^wb.adr[3:0];

    // Next state and outputs
    always_comb begin
        state_nxt    = state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 128'h0;
        wb.ack       = 1'b0;
        wb.dat_s     = 128'h0;

        case (state)
            IDLE: begin
                if (req) begin
                    if (hit)
                        state_nxt = RESP;
                    else if (valid && dirty)
                        state_nxt = WBACK;
                    else
                        state_nxt = FILL;
                end
            end
            WBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag, 4'h0};
                pmem_wdata   = data;
                // A dropped request still lets the writeback finish, then parks.
                if (pmem_resp)
                    state_nxt = req ? FILL : IDLE;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, 4'h0};
                if (pmem_resp)
                    state_nxt = req ? RESP : IDLE;
            end
            RESP: begin
                wb.ack = 1'b1;
                if (!wb.we)
                    wb.dat_s = data;
                // Always pass through IDLE so a held request is not taken twice.
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and line buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid   <= 1'b0;
            dirty   <= 1'b0;
            tag     <= 12'h000;
            data    <= 128'h0;
            req_tag <= 12'h000;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req)
                        req_tag <= wb.adr[15:4];
                end
                WBACK: begin
                    if (pmem_resp)
                        dirty <= 1'b0;
                end
                FILL: begin
                    if (pmem_resp) begin
                        data  <= pmem_rdata;
                        tag   <= req_tag;
                        valid <= 1'b1;
                        dirty <= 1'b0;
                    end
                end
                RESP: begin
                    if (wb.we) begin
                        // sel is active-low: a 0 bit enables that byte lane.
                        for (int i = 0; i < 16; i++) begin
                            if (!wb.sel[i])
                                data[8*i +: 8] <= wb.dat_m[8*i +: 8];
                        end
                        if (wb.sel != 16'hFFFF)
                            dirty <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_line_responder.sv
// Self-checking bench for wb_line_responder: directed scenarios plus randomized
// accesses checked against a behavioural line/memory model kept in the bench.
module tb_wb_line_responder;

    logic          clk = 1'b0;
    logic          rst;
    logic          pmem_read;
    logic          pmem_write;
    logic [15:0]   pmem_address;
    logic [127:0]  pmem_wdata;
    logic [127:0]  pmem_rdata;
    logic          pmem_resp;

    wishbone wb ();

    wb_line_responder dut (
        .clk          (clk),
        .rst          (rst),
        .wb           (wb),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    logic          m_valid;
    logic          m_dirty;
    logic [11:0]   m_tag;
    logic [127:0]  m_data;
    logic [127:0]  mem [logic [11:0]];

    logic          e_hit;
    logic          e_wb;
    logic [15:0]   e_wr_addr;
    logic [127:0]  e_wr_data;
    logic [127:0]  e_dat;

    function automatic logic [127:0] mem_get(input logic [11:0] t);
        if (!mem.exists(t))
            mem[t] = {$urandom, $urandom, $urandom, $urandom};
        return mem[t];
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_dirty = 1'b0;
        m_tag   = 12'h000;
        m_data  = 128'h0;
    endtask

    // Predict one access; 'abort' means the fill finishes but no ack/write happens.
    task automatic model_access(input logic we, input logic [15:0] a, input logic [15:0] s,
                                input logic [127:0] d, input logic abort);
        e_hit     = m_valid && (m_tag == a[15:4]);
        e_wb      = !e_hit && m_valid && m_dirty;
        e_wr_addr = {m_tag, 4'h0};
        e_wr_data = m_data;
        if (!e_hit) begin
            m_data  = mem_get(a[15:4]);
            m_tag   = a[15:4];
            m_valid = 1'b1;
            m_dirty = 1'b0;
        end
        e_dat = 128'h0;
        if (!abort) begin
            if (we) begin
                for (int i = 0; i < 16; i++)
                    if (!s[i]) m_data[8*i +: 8] = d[8*i +: 8];
                if (s != 16'hFFFF) m_dirty = 1'b1;
            end else begin
                e_dat = m_data;
            end
        end
    endtask

    // ---------------- bus driver / memory responder ----------------
    int            o_ack_cyc, o_fill_resp, o_first_wr, o_last_wr, o_first_rd, o_nwr, o_nrd;
    logic [127:0]  o_dat, o_wr_data;
    logic [15:0]   o_wr_addr, o_rd_addr;
    logic          o_overlap, o_unstable, o_leak, o_extra_ack, o_timeout;

    task automatic run_access(input logic we, input logic [15:0] a, input logic [15:0] s,
                              input logic [127:0] d, input logic abort);
        int   wait_n;
        logic busy;
        logic done;
        o_ack_cyc = -1; o_fill_resp = -1; o_first_wr = -1; o_last_wr = -1; o_first_rd = -1;
        o_nwr = 0; o_nrd = 0; o_dat = '0; o_wr_data = '0; o_wr_addr = '0; o_rd_addr = '0;
        o_overlap = 0; o_unstable = 0; o_leak = 0; o_extra_ack = 0; o_timeout = 0;
        busy = 0; wait_n = 0; done = 0;
        @(negedge clk);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we; wb.adr = a; wb.sel = s; wb.dat_m = d;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(negedge clk);
            if (wb.ack) begin
                if (o_ack_cyc < 0) begin
                    o_ack_cyc = c;
                    o_dat     = wb.dat_s;
                end else begin
                    o_extra_ack = 1'b1;
                end
            end else if (wb.dat_s !== 128'h0) begin
                o_leak = 1'b1;
            end
            if (pmem_read && pmem_write) o_overlap = 1'b1;
            if (pmem_write) begin
                if (o_first_wr < 0) begin
                    o_first_wr = c; o_wr_addr = pmem_address; o_wr_data = pmem_wdata;
                end else if (pmem_address !== o_wr_addr || pmem_wdata !== o_wr_data) begin
                    o_unstable = 1'b1;
                end
                o_last_wr = c;
            end
            if (pmem_read) begin
                if (o_first_rd < 0) begin
                    o_first_rd = c; o_rd_addr = pmem_address;
                    if (abort) begin
                        wb.cyc = 1'b0; wb.stb = 1'b0;
                    end
                end else if (pmem_address !== o_rd_addr) begin
                    o_unstable = 1'b1;
                end
            end
            // memory: one-cycle resp pulse after a random 0..3 cycle delay
            if (pmem_resp) begin
                pmem_resp  = 1'b0;
                pmem_rdata = '0;
                busy       = 1'b0;
            end else if (pmem_read || pmem_write) begin
                if (!busy) begin
                    busy   = 1'b1;
                    wait_n = $urandom_range(0, 3);
                end
                if (wait_n == 0) begin
                    pmem_resp = 1'b1;
                    if (pmem_read) begin
                        pmem_rdata  = mem_get(pmem_address[15:4]);
                        o_nrd++;
                        o_fill_resp = c;
                    end else begin
                        mem[pmem_address[15:4]] = pmem_wdata;
                        o_nwr++;
                    end
                end else begin
                    wait_n--;
                end
            end
            if (o_ack_cyc >= 0 && c == o_ack_cyc + 1) begin
                wb.cyc = 1'b0; wb.stb = 1'b0;
            end
            if (o_ack_cyc >= 0 && c >= o_ack_cyc + 2) done = 1'b1;
            if (abort && o_fill_resp >= 0 && c >= o_fill_resp + 4) done = 1'b1;
        end
        if (!done) o_timeout = 1'b1;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        pmem_resp = 1'b0; pmem_rdata = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (wb.ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b want 0", wb.ack); end
        n_cmp++; if (pmem_read !== 1'b0) begin n_bad++; $display("FAIL rst_pmem_read: got %b want 0", pmem_read); end
        n_cmp++; if (pmem_write !== 1'b0) begin n_bad++; $display("FAIL rst_pmem_write: got %b want 0", pmem_write); end
        n_cmp++; if (pmem_address !== 16'h0) begin n_bad++; $display("FAIL rst_pmem_address: got %h want 0", pmem_address); end
        n_cmp++; if (pmem_wdata !== 128'h0) begin n_bad++; $display("FAIL rst_pmem_wdata: got %h want 0", pmem_wdata); end
        n_cmp++; if (wb.dat_s !== 128'h0) begin n_bad++; $display("FAIL rst_dat_s: got %h want 0", wb.dat_s); end
        rst = 1'b0;
        model_reset();
        // stray pmem_resp in IDLE must be ignored
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        @(negedge clk);
        n_cmp++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || wb.ack !== 1'b0) begin
            n_bad++; $display("FAIL idle_resp_ignored: got rd=%b wr=%b ack=%b want 0 0 0", pmem_read, pmem_write, wb.ack);
        end
    endtask

    task automatic test_cold_miss();
        mem[12'h123] = {16{8'hA5}};
        model_access(1'b0, 16'h1234, 16'hFFFF, '0, 1'b0);
        run_access(1'b0, 16'h1234, 16'hFFFF, '0, 1'b0);
        n_cmp++; if (o_rd_addr !== 16'h1230) begin n_bad++; $display("FAIL cold_rd_addr: got %h want 1230", o_rd_addr); end
        n_cmp++; if (o_nwr !== 0 || o_nrd !== 1) begin n_bad++; $display("FAIL cold_pmem_ops: got wr=%0d rd=%0d want 0 1", o_nwr, o_nrd); end
        n_cmp++; if (o_ack_cyc !== o_fill_resp + 1 || o_fill_resp < 0) begin n_bad++; $display("FAIL cold_ack_latency: got ack=%0d fill_resp=%0d want resp+1", o_ack_cyc, o_fill_resp); end
        n_cmp++; if (o_dat !== {16{8'hA5}}) begin n_bad++; $display("FAIL cold_dat_s: got %h want a5..a5", o_dat); end
    endtask

    task automatic test_write_hit();
        logic [127:0] d;
        logic [127:0] exp;
        d = {$urandom, $urandom, $urandom, $urandom};
        d[47:32] = 16'hBEEF;
        exp = {16{8'hA5}};
        exp[47:32] = 16'hBEEF;
        model_access(1'b1, 16'h1234, 16'hFFCF, d, 1'b0);
        run_access(1'b1, 16'h1234, 16'hFFCF, d, 1'b0);
        n_cmp++; if (o_ack_cyc !== 1) begin n_bad++; $display("FAIL wr_hit_latency: got %0d want 1", o_ack_cyc); end
        n_cmp++; if (o_dat !== 128'h0 || o_leak) begin n_bad++; $display("FAIL wr_hit_dat_s: got %h leak=%b want 0", o_dat, o_leak); end
        n_cmp++; if (o_nwr !== 0 || o_nrd !== 0) begin n_bad++; $display("FAIL wr_hit_pmem: got wr=%0d rd=%0d want 0 0", o_nwr, o_nrd); end
        model_access(1'b0, 16'h1238, 16'hFFFF, '0, 1'b0);
        run_access(1'b0, 16'h1238, 16'hFFFF, '0, 1'b0);
        n_cmp++; if (o_dat !== exp) begin n_bad++; $display("FAIL wr_hit_reread: got %h want %h", o_dat, exp); end
    endtask

    task automatic test_dirty_evict();
        logic [127:0] exp;
        exp = {16{8'hA5}};
        exp[47:32] = 16'hBEEF;
        model_access(1'b0, 16'h5670, 16'hFFFF, '0, 1'b0);
        run_access(1'b0, 16'h5670, 16'hFFFF, '0, 1'b0);
        n_cmp++; if (o_nwr !== 1 || o_wr_addr !== 16'h1230) begin n_bad++; $display("FAIL evict_wr_addr: got n=%0d addr=%h want 1 1230", o_nwr, o_wr_addr); end
        n_cmp++; if (o_wr_data !== exp) begin n_bad++; $display("FAIL evict_wr_data: got %h want %h", o_wr_data, exp); end
        n_cmp++; if (o_rd_addr !== 16'h5670 || o_nrd !== 1) begin n_bad++; $display("FAIL evict_rd_addr: got n=%0d addr=%h want 1 5670", o_nrd, o_rd_addr); end
        n_cmp++; if (!(o_first_wr >= 0 && o_last_wr < o_first_rd) || o_overlap) begin
            n_bad++; $display("FAIL evict_order: got wr %0d..%0d rd %0d overlap=%b want wr before rd", o_first_wr, o_last_wr, o_first_rd, o_overlap);
        end
        n_cmp++; if (o_ack_cyc !== o_fill_resp + 1 || o_dat !== e_dat) begin n_bad++; $display("FAIL evict_ack: got cyc=%0d dat=%h want %0d %h", o_ack_cyc, o_dat, o_fill_resp + 1, e_dat); end
    endtask

    task automatic test_clean_miss();
        model_access(1'b0, 16'h9AB0, 16'hFFFF, '0, 1'b0);
        run_access(1'b0, 16'h9AB0, 16'hFFFF, '0, 1'b0);
        n_cmp++; if (o_nwr !== 0 || o_nrd !== 1 || o_rd_addr !== 16'h9AB0) begin
            n_bad++; $display("FAIL clean_miss: got wr=%0d rd=%0d addr=%h want 0 1 9ab0", o_nwr, o_nrd, o_rd_addr);
        end
        n_cmp++; if (o_dat !== e_dat) begin n_bad++; $display("FAIL clean_miss_dat: got %h want %h", o_dat, e_dat); end
    endtask

    task automatic test_abort();
        model_access(1'b0, 16'hDEF0, 16'hFFFF, '0, 1'b1);
        run_access(1'b0, 16'hDEF0, 16'hFFFF, '0, 1'b1);
        n_cmp++; if (o_ack_cyc !== -1 || o_nrd !== 1 || o_timeout) begin
            n_bad++; $display("FAIL abort_no_ack: got ack=%0d rd=%0d to=%b want -1 1 0", o_ack_cyc, o_nrd, o_timeout);
        end
        n_cmp++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got rd=%b wr=%b want 0 0", pmem_read, pmem_write); end
        model_access(1'b0, 16'hDEF4, 16'hFFFF, '0, 1'b0);
        run_access(1'b0, 16'hDEF4, 16'hFFFF, '0, 1'b0);
        n_cmp++; if (o_ack_cyc !== 1 || o_nrd !== 0 || o_dat !== e_dat) begin
            n_bad++; $display("FAIL abort_rehit: got cyc=%0d rd=%0d dat=%h want 1 0 %h", o_ack_cyc, o_nrd, o_dat, e_dat);
        end
    endtask

    task automatic test_sel_none();
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        model_access(1'b1, 16'hDEF8, 16'hFFFF, d, 1'b0);
        run_access(1'b1, 16'hDEF8, 16'hFFFF, d, 1'b0);
        n_cmp++; if (o_ack_cyc !== 1) begin n_bad++; $display("FAIL sel_none_ack: got %0d want 1", o_ack_cyc); end
        model_access(1'b0, 16'h1110, 16'hFFFF, '0, 1'b0);
        run_access(1'b0, 16'h1110, 16'hFFFF, '0, 1'b0);
        n_cmp++; if (o_nwr !== 0 || o_nrd !== 1) begin n_bad++; $display("FAIL sel_none_clean: got wr=%0d rd=%0d want 0 1", o_nwr, o_nrd); end
    endtask

    task automatic test_random();
        logic [11:0] tags [4];
        logic [15:0] a, s;
        logic [127:0] d;
        logic we;
        tags[0] = 12'h123; tags[1] = 12'h567; tags[2] = 12'h9AB; tags[3] = 12'hCDE;
        for (int k = 0; k < 40; k++) begin
            a  = {tags[$urandom_range(0, 3)], 4'($urandom)};
            we = 1'($urandom);
            s  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            d  = {$urandom, $urandom, $urandom, $urandom};
            model_access(we, a, s, d, 1'b0);
            run_access(we, a, s, d, 1'b0);
            n_cmp++; if (o_timeout || o_ack_cyc !== (e_hit ? 1 : o_fill_resp + 1)) begin
                n_bad++; $display("FAIL rnd%0d_latency: got ack=%0d fill=%0d to=%b hit=%b", k, o_ack_cyc, o_fill_resp, o_timeout, e_hit);
            end
            n_cmp++; if (o_dat !== e_dat) begin n_bad++; $display("FAIL rnd%0d_dat: got %h want %h", k, o_dat, e_dat); end
            n_cmp++; if (o_nwr !== (e_wb ? 1 : 0) || (e_wb && (o_wr_addr !== e_wr_addr || o_wr_data !== e_wr_data))) begin
                n_bad++; $display("FAIL rnd%0d_wback: got n=%0d %h %h want n=%0d %h %h", k, o_nwr, o_wr_addr, o_wr_data, e_wb, e_wr_addr, e_wr_data);
            end
            n_cmp++; if (o_nrd !== (e_hit ? 0 : 1) || (!e_hit && o_rd_addr !== {a[15:4], 4'h0})) begin
                n_bad++; $display("FAIL rnd%0d_fill: got n=%0d addr=%h want hit=%b addr=%h", k, o_nrd, o_rd_addr, e_hit, {a[15:4], 4'h0});
            end
            n_cmp++; if (o_overlap || o_unstable || o_leak || o_extra_ack) begin
                n_bad++; $display("FAIL rnd%0d_protocol: got ovl=%b unst=%b leak=%b xack=%b want 0", k, o_overlap, o_unstable, o_leak, o_extra_ack);
            end
        end
    endtask

    task automatic test_reset_mid_wback();
        logic seen;
        logic [15:0] old_a;
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        old_a = {m_valid ? m_tag : 12'h777, 4'h0};
        model_access(1'b1, old_a, 16'h0000, d, 1'b0);
        run_access(1'b1, old_a, 16'h0000, d, 1'b0);
        seen = 1'b0;
        @(negedge clk);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = old_a ^ 16'h8000; wb.sel = 16'hFFFF;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (pmem_write) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL rstwb_write_seen: got 0 want 1"); end
        rst = 1'b1;
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        n_cmp++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || wb.ack !== 1'b0 || pmem_address !== 16'h0) begin
            n_bad++; $display("FAIL rstwb_outputs: got wr=%b rd=%b ack=%b addr=%h want 0", pmem_write, pmem_read, wb.ack, pmem_address);
        end
        rst = 1'b0;
        wb.cyc = 1'b0; wb.stb = 1'b0;
        model_reset();
        model_access(1'b0, old_a, 16'hFFFF, '0, 1'b0);
        run_access(1'b0, old_a, 16'hFFFF, '0, 1'b0);
        n_cmp++; if (o_nwr !== 0 || o_nrd !== 1 || o_ack_cyc !== o_fill_resp + 1) begin
            n_bad++; $display("FAIL rstwb_next_miss: got wr=%0d rd=%0d ack=%0d want 0 1 %0d", o_nwr, o_nrd, o_ack_cyc, o_fill_resp + 1);
        end
        n_cmp++; if (o_dat !== e_dat) begin n_bad++; $display("FAIL rstwb_dat: got %h want %h", o_dat, e_dat); end
    endtask

    initial begin
        rst = 1'b1;
        pmem_resp = 1'b0; pmem_rdata = '0;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        wb.adr = '0; wb.sel = 16'hFFFF; wb.dat_m = '0;
        model_reset();
        test_reset();
        test_cold_miss();
        test_write_hit();
        test_dirty_evict();
        test_clean_miss();
        test_abort();
        test_sel_none();
        test_random();
        test_reset_mid_wback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/wb_line_responder.md
WB_LINE_RESPONDER -- requirements
Module: wb_line_responder

Interface
REQ-001 The module SHALL have these ports: clk  input  1  system clock; all state updates on rising edge.
REQ-002 The module SHALL have these ports: rst  input  1  reset, synchronous, active-high.
REQ-003 The module SHALL have these ports: wb  wishbone.slave  --  CYC, STB, WE, ADR[15:0], SEL[15:0], DAT_M[127:0] in; DAT_S[127:0], ACK out.
REQ-004 The module SHALL have these ports: pmem_read  output  1  line fill request to physical memory.
REQ-005 The module SHALL have these ports: pmem_write  output  1  line writeback request to physical memory.
REQ-006 The module SHALL have these ports: pmem_address  output  16  line-aligned address, bits [3:0] = 0.
REQ-007 The module SHALL have these ports: pmem_wdata  output  128  writeback line data.
REQ-008 The module SHALL have these ports: pmem_rdata  input  128  fill line data, valid when pmem_resp = 1.
REQ-009 The module SHALL have these ports: pmem_resp  input  1  one-cycle completion pulse for pmem_read/pmem_write.

Function
REQ-010 The module SHALL hold one line buffer: valid, dirty, tag[11:0], data[127:0]; line tag = ADR[15:4].
REQ-011 The module SHALL accept a request only in IDLE, when CYC & STB = 1.
REQ-012 The module SHALL use states IDLE, WBACK, FILL, RESP.
REQ-013 IDLE transitions SHALL be: hit (valid & tag == ADR[15:4]) -> RESP; miss & valid & dirty -> WBACK; other miss -> FILL; no request -> IDLE.
REQ-014 In WBACK the module SHALL drive pmem_write = 1, pmem_address = {tag, 4'b0}, pmem_wdata = data, held stable until pmem_resp; on pmem_resp -> FILL and dirty cleared.
REQ-015 In FILL the module SHALL drive pmem_read = 1, pmem_address = {ADR[15:4], 4'b0}, held until pmem_resp; on pmem_resp: data <= pmem_rdata, tag <= ADR[15:4], valid <= 1, dirty <= 0, -> RESP.
REQ-016 In RESP the module SHALL assert ACK for exactly one cycle, then -> IDLE.
REQ-017 For a read in RESP, DAT_S SHALL equal the buffer data; DAT_S SHALL be 0 in all other cycles.
REQ-018 For a write in RESP, for each byte lane i with SEL[i] = 0 (active-low lane select), data[8i+7:8i] SHALL be updated to DAT_M[8i+7:8i] at the ACK edge; lanes with SEL[i] = 1 SHALL be unchanged.
REQ-019 A write SHALL set dirty only if at least one SEL bit is 0; SEL = 16'hFFFF SHALL ACK with no line or dirty change.
REQ-020 Hit latency SHALL be: request sampled in IDLE at cycle N, ACK in cycle N+1.
REQ-021 Miss latency SHALL be: ACK exactly one cycle after the FILL pmem_resp.
REQ-022 Because of the mandatory IDLE cycle after RESP, the same held request SHALL NOT be accepted twice.
REQ-023 If CYC or STB drops during WBACK/FILL, the pending pmem transaction SHALL complete (buffer updated per REQ-014/015), then -> IDLE with no ACK.
REQ-024 pmem_read and pmem_write SHALL never be asserted together, and SHALL be 0 in IDLE and RESP.
REQ-025 pmem_resp outside WBACK/FILL SHALL be ignored.
REQ-026 ADR, WE, SEL and DAT_M SHALL be sampled directly from wb; the master holds them stable until ACK.

Reset
REQ-027 When rst = 1 at a clock edge, the state SHALL become IDLE and valid, dirty, tag and data SHALL be 0.
REQ-028 Outputs SHALL read 0 in the cycle after a reset edge: ACK, pmem_read, pmem_write, pmem_address, pmem_wdata, DAT_S.
REQ-029 Reset SHALL take priority over all other events, including a concurrent pmem_resp or request.
REQ-030 Reset mid-WBACK/FILL SHALL abandon the transaction, with outputs deasserted the following cycle.

Verification
REQ-031 Scenario, cold read miss: read ADR = 16'h1234 after reset -> pmem_read with pmem_address = 16'h1230; return pmem_rdata = 128'hA5..A5 -> ACK 1 cycle later with DAT_S = 128'hA5..A5.
REQ-032 Scenario, write hit lanes: after REQ-031, write ADR = 16'h1234, SEL = 16'hFFCF, DAT_M lanes 4-5 = 16'hBEEF -> ACK at N+1; a re-read returns 16'hBEEF in lanes 4-5 and A5 elsewhere, dirty = 1.
REQ-033 Scenario, dirty eviction: read ADR = 16'h5670 -> pmem_write at 16'h1230 with the modified line, then pmem_read at 16'h5670, then ACK; check the order and that the two requests never overlap.
REQ-034 Scenario, clean miss: read a clean line's miss address -> no pmem_write; pmem_read issued directly.
REQ-035 Scenario, abort: drop STB during FILL -> the fill completes, no ACK, state returns to IDLE; a subsequent read of the same line is a hit with ACK at N+1.
REQ-036 Scenario, reset mid-WBACK: assert rst -> pmem_write = 0 next cycle, valid = 0, and the next read misses.
